// File: rtl/mips32_pipe_pkg.sv
`default_nettype none
// ============================================================================
// mips32_pipe_pkg
// Shared types for the MIPS32 ID/EX stage: forward selects, control bundle.
// Revision: 1.0
// ============================================================================
package mips32_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_EX  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic reg_dst;
    logic alu_src;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_hazard_unit.sv
`default_nettype none
// ============================================================================
// id_ex_hazard_unit
// Combinational forward-select generation and stall request. Behaviour
// depends on ID_EX_FWD_EN (forwarding + load-use stall vs. RAW stall only).
// Revision: 1.0
// ============================================================================
module id_ex_hazard_unit
  import mips32_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_reg_write_i,
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  memwb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  output fwd_sel_t              fwd_a_o,
  output fwd_sel_t              fwd_b_o,
  output logic                  stall_req_o
);

  logic w_unused;

`ifdef ID_EX_FWD_EN
  // EX/MEM is checked first so the younger result wins; $0 never forwards.
  function automatic fwd_sel_t pick_src(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  em_we,
    input logic [REG_ADDR_W-1:0] em_rd,
    input logic                  mw_we,
    input logic [REG_ADDR_W-1:0] mw_rd
  );
    if (em_we && (em_rd != '0) && (em_rd == src)) begin
      return FWD_EX;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
      return FWD_MEM;
    end
    return FWD_RF;
  endfunction

  logic w_load_use;

  always_comb begin
    fwd_a_o = pick_src(ex_rs_i, exmem_reg_write_i, exmem_rd_i,
                       memwb_reg_write_i, memwb_rd_i);
    fwd_b_o = pick_src(ex_rt_i, exmem_reg_write_i, exmem_rd_i,
                       memwb_reg_write_i, memwb_rd_i);
  end

  assign w_load_use  = id_valid_i && ex_valid_i && ex_mem_read_i &&
                       (ex_rt_i != '0) &&
                       ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  assign stall_req_o = w_load_use && !flush_i;
  assign w_unused    = ^{ex_reg_write_i, ex_dest_i};
`else
  // Without forwarding, any pending write in EX or MEM blocks decode;
  // WB writes land in the register file early enough to be read.
  function automatic logic raw_hit(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  ex_we,
    input logic [REG_ADDR_W-1:0] ex_dst,
    input logic                  em_we,
    input logic [REG_ADDR_W-1:0] em_dst
  );
    return (src != '0) &&
           ((ex_we && (src == ex_dst)) || (em_we && (src == em_dst)));
  endfunction

  logic w_ex_writes;
  logic w_raw;

  assign fwd_a_o     = FWD_RF;
  assign fwd_b_o     = FWD_RF;
  assign w_ex_writes = ex_valid_i && ex_reg_write_i;
  assign w_raw       = id_valid_i &&
                       (raw_hit(id_rs_i, w_ex_writes, ex_dest_i,
                                exmem_reg_write_i, exmem_rd_i) ||
                        raw_hit(id_rt_i, w_ex_writes, ex_dest_i,
                                exmem_reg_write_i, exmem_rd_i));
  assign stall_req_o = w_raw && !flush_i;
  assign w_unused    = ^{ex_rs_i, ex_rt_i, ex_mem_read_i,
                         memwb_reg_write_i, memwb_rd_i};
`endif

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage
// MIPS32 ID/EX register with operand forwarding, RegDst/ALUSrc muxing and
// load-use hold/flush control. Forwarding is enabled by ID_EX_FWD_EN.
// Revision: 1.0
// ============================================================================
module id_ex_stage
  import mips32_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_read_data_1,
  input  logic [DATA_W-1:0]     id_read_data_2,
  input  logic [DATA_W-1:0]     id_sign_extend,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_alu_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_write_data,
  output logic                  stall_req,
  output logic [DATA_W-1:0]     ex_operand_a,
  output logic [DATA_W-1:0]     ex_operand_b,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dest_reg,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [1:0]            ex_fwd_a,
  output logic [1:0]            ex_fwd_b
);

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     rd1_q, rd1_d;
  logic [DATA_W-1:0]     rd2_q, rd2_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  id_ex_ctrl_t           ctrl_q, ctrl_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;

  id_ex_ctrl_t           w_id_ctrl;
  logic [REG_ADDR_W-1:0] w_dest;
  fwd_sel_t              w_fwd_a;
  fwd_sel_t              w_fwd_b;
  logic                  w_stall;
  logic [DATA_W-1:0]     w_val_a;
  logic [DATA_W-1:0]     w_val_b;

  assign w_id_ctrl = '{
    reg_write:  id_reg_write,
    mem_to_reg: id_mem_to_reg,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    reg_dst:    id_reg_dst,
    alu_src:    id_alu_src
  };

  // flush > hold > stall > load; a bubble is simply an all-zero register.
  always_comb begin
    valid_d  = valid_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    ctrl_d   = ctrl_q;
    alu_op_d = alu_op_q;
    if (flush || (!hold && w_stall)) begin
      valid_d  = 1'b0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      rd1_d    = '0;
      rd2_d    = '0;
      imm_d    = '0;
      ctrl_d   = BUBBLE;
      alu_op_d = '0;
    end else if (!hold) begin
      valid_d  = id_valid;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
      rd1_d    = id_read_data_1;
      rd2_d    = id_read_data_2;
      imm_d    = id_sign_extend;
      ctrl_d   = w_id_ctrl;
      alu_op_d = id_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      ctrl_q   <= BUBBLE;
      alu_op_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign w_dest = ctrl_q.reg_dst ? rd_q : rt_q;

  id_ex_hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .id_valid_i        (id_valid),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .flush_i           (flush),
    .ex_valid_i        (valid_q),
    .ex_mem_read_i     (ctrl_q.mem_read),
    .ex_reg_write_i    (ctrl_q.reg_write),
    .ex_rs_i           (rs_q),
    .ex_rt_i           (rt_q),
    .ex_dest_i         (w_dest),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .fwd_a_o           (w_fwd_a),
    .fwd_b_o           (w_fwd_b),
    .stall_req_o       (w_stall)
  );

  always_comb begin
    case (w_fwd_a)
      FWD_EX:  w_val_a = exmem_alu_result;
      FWD_MEM: w_val_a = memwb_write_data;
      default: w_val_a = rd1_q;
    endcase
    case (w_fwd_b)
      FWD_EX:  w_val_b = exmem_alu_result;
      FWD_MEM: w_val_b = memwb_write_data;
      default: w_val_b = rd2_q;
    endcase
  end

  assign stall_req     = w_stall;
  assign ex_operand_a  = w_val_a;
  assign ex_operand_b  = ctrl_q.alu_src ? imm_q : w_val_b;
  assign ex_store_data = w_val_b;
  assign ex_dest_reg   = w_dest;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_op     = alu_op_q;
  assign ex_fwd_a      = w_fwd_a;
  assign ex_fwd_b      = w_fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage
// Directed bench with a per-cycle reference model for id_ex_stage.
// Revision: 1.0
// ============================================================================
module tb_id_ex_stage;

  localparam logic [5:0] C_NONE = 6'b000000;  // {rw,m2r,mr,mw,rdst,asrc}
  localparam logic [5:0] C_ADD  = 6'b100010;
  localparam logic [5:0] C_LW   = 6'b111001;
  localparam logic [5:0] C_ADDI = 6'b100001;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, id_valid, hold, flush;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_read_data_1, id_read_data_2, id_sign_extend;
  logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
  logic        id_reg_dst, id_alu_src;
  logic [2:0]  id_alu_op;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_alu_result, memwb_write_data;
  logic        stall_req;
  logic [31:0] ex_operand_a, ex_operand_b, ex_store_data;
  logic [4:0]  ex_dest_reg;
  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_alu_op;
  logic [1:0]  ex_fwd_a, ex_fwd_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
    .id_sign_extend(id_sign_extend),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .hold(hold), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_alu_result(exmem_alu_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_write_data(memwb_write_data),
    .stall_req(stall_req), .ex_operand_a(ex_operand_a),
    .ex_operand_b(ex_operand_b), .ex_store_data(ex_store_data),
    .ex_dest_reg(ex_dest_reg), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_op(ex_alu_op), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic        rw, m2r, mr, mw, rdst, asrc;
    logic [2:0]  op;
  } instr_t;

  instr_t m;
  bit     m_known = 1'b0;

  function automatic logic [4:0] m_dest();
    return m.rdst ? m.rd : m.rt;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (!FWD || r == 5'd0) return 2'b00;
    if (exmem_reg_write && exmem_rd == r) return 2'b10;
    if (memwb_reg_write && memwb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_val(input logic [1:0] s, input logic [31:0] rf);
    if (s == 2'b10) return exmem_alu_result;
    if (s == 2'b01) return memwb_write_data;
    return rf;
  endfunction

  function automatic logic exp_stall();
    logic hz;
    if (flush || !id_valid) return 1'b0;
    if (FWD) begin
      hz = m.valid && m.mr && m.rt != 5'd0 && (m.rt == id_rs || m.rt == id_rt);
    end else begin
      hz = 1'b0;
      foreach (id_rs[i]) begin end
      if (id_rs != 5'd0 && ((m.valid && m.rw && id_rs == m_dest()) ||
                            (exmem_reg_write && id_rs == exmem_rd))) hz = 1'b1;
      if (id_rt != 5'd0 && ((m.valid && m.rw && id_rt == m_dest()) ||
                            (exmem_reg_write && id_rt == exmem_rd))) hz = 1'b1;
    end
    return hz;
  endfunction

  always @(posedge clk) begin
    logic st;
    st = exp_stall();
    if (reset) begin
      m = '{default: '0};
      m_known = 1'b1;
    end else if (flush || (!hold && st)) begin
      m = '{default: '0};
    end else if (!hold) begin
      m = '{id_valid, id_rs, id_rt, id_rd, id_read_data_1, id_read_data_2,
            id_sign_extend, id_reg_write, id_mem_to_reg, id_mem_read,
            id_mem_write, id_reg_dst, id_alu_src, id_alu_op};
    end
  end

  always @(negedge clk) begin
    logic [1:0]  fa, fb;
    logic [31:0] vb;
    if (m_known) begin
      fa = exp_fwd(m.rs);
      fb = exp_fwd(m.rt);
      vb = exp_val(fb, m.rd2);
      chk("m_stall", stall_req, exp_stall());
      chk("m_opa", ex_operand_a, exp_val(fa, m.rd1));
      chk("m_opb", ex_operand_b, m.asrc ? m.imm : vb);
      chk("m_store", ex_store_data, vb);
      chk("m_dest", ex_dest_reg, m_dest());
      chk("m_ctrl", {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read,
                     ex_mem_write, ex_alu_op},
                    {m.valid, m.rw, m.m2r, m.mr, m.mw, m.op});
      chk("m_fwd", {ex_fwd_a, ex_fwd_b}, {fa, fb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm,
                        input logic [5:0] ctl, input logic [2:0] op);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_read_data_1 = d1; id_read_data_2 = d2; id_sign_extend = imm;
    {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
     id_reg_dst, id_alu_src} = ctl;
    id_alu_op = op;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ev,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mv);
    exmem_reg_write = ew; exmem_rd = erd; exmem_alu_result = ev;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_write_data = mv;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, C_NONE, 3'd0);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    idle();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_dest", ex_dest_reg, 5'd0);
    chk("rst_opa", ex_operand_a, 32'd0);
    chk("rst_stall", stall_req, 1'b0);

    // add $3,$1,$2
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, C_ADD, 3'd2);
    tick(); idle(); #1;
    chk("add_opa", ex_operand_a, 32'd5);
    chk("add_opb", ex_operand_b, 32'd7);
    chk("add_dest", ex_dest_reg, 5'd3);
    chk("add_fwd", {ex_fwd_a, ex_fwd_b}, 4'b0000);

    // both stages write $1: EX/MEM wins
    set_fwd(1'b1, 5'd1, 32'hAA, 1'b1, 5'd1, 32'hBB); #1;
    chk("exfwd_sel", ex_fwd_a, FWD ? 2'b10 : 2'b00);
    chk("exfwd_opa", ex_operand_a, FWD ? 32'hAA : 32'd5);
    set_fwd(1'b0, 5'd1, 32'hAA, 1'b1, 5'd2, 32'hBB); #1;
    chk("memfwd_selb", ex_fwd_b, FWD ? 2'b01 : 2'b00);
    chk("memfwd_store", ex_store_data, FWD ? 32'hBB : 32'd7);

    // rs=0 is never forwarded
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd0, 5'd7, 5'd8, 32'h11, 32'h22, 32'd0, C_ADD, 3'd2);
    tick(); idle();
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB); #1;
    chk("zero_fwd", ex_fwd_a, 2'b00);
    chk("zero_opa", ex_operand_a, 32'h11);

    // lw $4,8($0) followed by add $5,$4,$6
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd0, 5'd4, 5'd0, 32'h100, 32'd0, 32'd8, C_LW, 3'd0);
    tick();
    set_id(1'b1, 5'd4, 5'd6, 5'd5, 32'h44, 32'h66, 32'd0, C_ADD, 3'd2); #1;
    chk("lu_stall", stall_req, 1'b1);
    chk("lu_dest", ex_dest_reg, 5'd4);
    chk("lu_opb", ex_operand_b, 32'd8);
    tick();
    set_fwd(1'b1, 5'd4, 32'h108, 1'b0, 5'd0, 32'd0); #1;
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_stall2", stall_req, FWD ? 1'b0 : 1'b1);
    tick();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hDEAD);
    if (FWD) begin
      idle(); #1;
      chk("lu_valid", ex_valid, 1'b1);
      chk("lu_fwda", ex_fwd_a, 2'b01);
      chk("lu_opa", ex_operand_a, 32'hDEAD);
    end else begin
      #1;
      chk("lu_bubble2", ex_valid, 1'b0);
      chk("lu_nostall", stall_req, 1'b0);
      tick(); idle();
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); #1;
      chk("lu_valid", ex_valid, 1'b1);
      chk("lu_opa", ex_operand_a, 32'h44);
    end
    chk("lu_adddest", ex_dest_reg, 5'd5);

    // hold keeps the lw despite the hazard, then flush wins over stall
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd0, 5'd4, 5'd0, 32'h100, 32'd0, 32'd8, C_LW, 3'd0);
    tick();
    set_id(1'b1, 5'd4, 5'd6, 5'd5, 32'h44, 32'h66, 32'd0, C_ADD, 3'd2);
    hold = 1'b1; #1;
    chk("hold_stall", stall_req, 1'b1);
    tick(); #1;
    chk("hold_kept", {ex_valid, ex_mem_read}, 2'b11);
    hold = 1'b0; flush = 1'b1; #1;
    chk("flush_stall", stall_req, 1'b0);
    tick(); flush = 1'b0; idle(); #1;
    chk("flush_bubble", {ex_valid, ex_reg_write, ex_mem_read}, 3'b000);

    // addi $9,$1,-4 frozen for 3 cycles
    set_id(1'b1, 5'd1, 5'd9, 5'd0, 32'h10, 32'd0, 32'hFFFF_FFFC, C_ADDI, 3'd2);
    tick();
    set_id(1'b1, 5'd2, 5'd3, 5'd10, 32'h22, 32'h33, 32'd0, C_ADD, 3'd2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_opb", ex_operand_b, 32'hFFFF_FFFC);
      chk("hold_dest", ex_dest_reg, 5'd9);
      tick();
    end
    hold = 1'b0; #1;
    chk("hold_end_opb", ex_operand_b, 32'hFFFF_FFFC);
    tick(); idle(); #1;
    chk("after_hold_dest", ex_dest_reg, 5'd10);
    chk("after_hold_opb", ex_operand_b, 32'h33);

    // reset while a load-use stall is pending
    set_id(1'b1, 5'd0, 5'd4, 5'd0, 32'h100, 32'd0, 32'd8, C_LW, 3'd0);
    tick();
    set_id(1'b1, 5'd6, 5'd4, 5'd5, 32'h66, 32'h44, 32'd0, C_ADD, 3'd2); #1;
    chk("rs_stall", stall_req, 1'b1);
    reset = 1'b1;
    tick(); #1;
    chk("rs_bubble", ex_valid, 1'b0);
    chk("rs_nostall", stall_req, 1'b0);
    reset = 1'b0; idle();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
